// File: rtl/ks_voice_scheduler_if.sv
// Engine job interface between the voice scheduler (master) and the shared
// Karplus-Strong string engine (slave).
interface ks_voice_scheduler_if #(
   parameter int SAMPLE_W = 16
);
   logic                eng_start;
   logic [2:0]          eng_voice;
   logic                eng_pluck;
   logic                eng_done;
   logic [SAMPLE_W-1:0] eng_sample;

   modport master (
      output eng_start,
      output eng_voice,
      output eng_pluck,
      input  eng_done,
      input  eng_sample
   );

   modport slave (
      input  eng_start,
      input  eng_voice,
      input  eng_pluck,
      output eng_done,
      output eng_sample
   );
endinterface

// File: rtl/ks_voice_scheduler.sv
// Round-robin scheduler sharing one Karplus-Strong engine across NUM_VOICES voices,
// producing one saturated mixed sample per audio tick.
module ks_voice_scheduler #(
   parameter int NUM_VOICES = 6,
   parameter int SAMPLE_W   = 16,
   parameter int DIV_W      = 32,
   parameter int MIN_PERIOD = 16,
   parameter int MIX_SHIFT  = 1
) (
   input  logic                           clk_clk,
   input  logic                           reset_reset,
   input  logic [DIV_W-1:0]               div_freq,
   input  logic [NUM_VOICES-1:0]          pluck_req,
   input  logic                           overrun_clr,
   ks_voice_scheduler_if.master           eng,
   output logic [NUM_VOICES*SAMPLE_W-1:0] voice_samples,
   output logic [SAMPLE_W-1:0]            mix_out,
   output logic                           mix_valid,
   output logic                           busy,
   output logic                           overrun
);

   localparam int                      ACC_W      = SAMPLE_W + 3;
   localparam logic [2:0]              LAST_IDX   = 3'(NUM_VOICES - 1);
   localparam logic [DIV_W-1:0]        MIN_RELOAD = DIV_W'(MIN_PERIOD - 1);
   localparam logic signed [ACC_W-1:0] SAT_HI     = ACC_W'((1 << (SAMPLE_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_LO     = ~SAT_HI;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_START  = 2'd1,
      S_WAIT   = 2'd2,
      S_OUTPUT = 2'd3
   } state_t;

   function automatic logic [SAMPLE_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
      logic [SAMPLE_W-1:0] r;
      if (v > SAT_HI) begin
         r = SAT_HI[SAMPLE_W-1:0];
      end else if (v < SAT_LO) begin
         r = SAT_LO[SAMPLE_W-1:0];
      end else begin
         r = v[SAMPLE_W-1:0];
      end
      return r;
   endfunction

   state_t                    state_r;
   state_t                    state_s;
   logic [DIV_W-1:0]          cnt_r;
   logic [DIV_W-1:0]          reload_s;
   logic                      tick_s;
   logic [2:0]                idx_r;
   logic signed [ACC_W-1:0]   acc_r;
   logic [NUM_VOICES-1:0]     pluck_pend_r;
   logic [NUM_VOICES-1:0]     pluck_clr_s;
   logic                      eng_start_s;
   logic signed [ACC_W-1:0]   sample_ext_s;

   assign reload_s     = (div_freq < DIV_W'(MIN_PERIOD)) ? MIN_RELOAD : (div_freq - DIV_W'(1));
   assign tick_s       = (cnt_r == {DIV_W{1'b0}});
   assign eng_start_s  = (state_r == S_START);
   assign sample_ext_s = ACC_W'($signed(eng.eng_sample));

   assign eng.eng_start = eng_start_s;
   assign eng.eng_voice = idx_r;
   assign eng.eng_pluck = eng_start_s & pluck_pend_r[idx_r];
   assign busy          = (state_r != S_IDLE);

   // Sample-period down-counter; div_freq is only looked at on reload.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         cnt_r <= reload_s;
      end else if (tick_s) begin
         cnt_r <= reload_s;
      end else begin
         cnt_r <= cnt_r - DIV_W'(1);
      end
   end

   // FSM state register.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (tick_s) begin
               state_s = S_START;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_START: state_s = S_WAIT;
         S_WAIT: begin
            if (eng.eng_done) begin
               if (idx_r == LAST_IDX) begin
                  state_s = S_OUTPUT;
               end else begin
                  state_s = S_START;
               end
            end else begin
               state_s = S_WAIT;
            end
         end
         S_OUTPUT: state_s = S_IDLE;
         default:  state_s = S_IDLE;
      endcase
   end

   // A pending pluck is consumed when its voice is issued to the engine.
   always_comb begin
      pluck_clr_s = {NUM_VOICES{1'b0}};
      if (eng_start_s && pluck_pend_r[idx_r]) begin
         pluck_clr_s[idx_r] = 1'b1;
      end else begin
         pluck_clr_s = {NUM_VOICES{1'b0}};
      end
   end

   // Datapath: voice index, accumulator, per-voice samples, mix and status flags.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         idx_r         <= 3'd0;
         acc_r         <= {ACC_W{1'b0}};
         pluck_pend_r  <= {NUM_VOICES{1'b0}};
         voice_samples <= {(NUM_VOICES*SAMPLE_W){1'b0}};
         mix_out       <= {SAMPLE_W{1'b0}};
         mix_valid     <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         mix_valid    <= 1'b0;
         // A new request in the same cycle as the consume keeps the bit set.
         pluck_pend_r <= (pluck_pend_r & ~pluck_clr_s) | pluck_req;
         if (tick_s && (state_r != S_IDLE)) begin
            overrun <= 1'b1;
         end else if (overrun_clr) begin
            overrun <= 1'b0;
         end else begin
            overrun <= overrun;
         end
         case (state_r)
            S_IDLE: begin
               if (tick_s) begin
                  idx_r <= 3'd0;
                  acc_r <= {ACC_W{1'b0}};
               end
            end
            S_WAIT: begin
               if (eng.eng_done) begin
                  for (int i = 0; i < NUM_VOICES; i++) begin
                     if (idx_r == 3'(i)) begin
                        voice_samples[i*SAMPLE_W +: SAMPLE_W] <= eng.eng_sample;
                     end
                  end
                  acc_r <= acc_r + sample_ext_s;
                  if (idx_r != LAST_IDX) begin
                     idx_r <= idx_r + 3'd1;
                  end
               end
            end
            S_OUTPUT: begin
               mix_out   <= saturate(acc_r >>> MIX_SHIFT);
               mix_valid <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ks_voice_scheduler.sv
// Directed bench for ks_voice_scheduler with a behavioural string-engine model
// of programmable latency returning a per-voice sample table.
module tb_ks_voice_scheduler;
   localparam int NV = 6;
   localparam int SW = 16;

   logic              clk = 1'b0;
   logic              reset_reset;
   logic [31:0]       div_freq;
   logic [NV-1:0]     pluck_req;
   logic              overrun_clr;
   logic [NV*SW-1:0]  voice_samples;
   logic [SW-1:0]     mix_out;
   logic              mix_valid;
   logic              busy;
   logic              overrun;

   int n_checks = 0;
   int n_pass   = 0;

   ks_voice_scheduler_if #(.SAMPLE_W(SW)) eng ();

   ks_voice_scheduler dut (
      .clk_clk       (clk),
      .reset_reset   (reset_reset),
      .div_freq      (div_freq),
      .pluck_req     (pluck_req),
      .overrun_clr   (overrun_clr),
      .eng           (eng),
      .voice_samples (voice_samples),
      .mix_out       (mix_out),
      .mix_valid     (mix_valid),
      .busy          (busy),
      .overrun       (overrun)
   );

   always #5 clk = ~clk;

   // Engine model: eng_done comes lat cycles after the start it answers.
   int                lat = 3;
   int                cnt_m = 0;
   logic [2:0]        cur_voice = 3'd0;
   logic signed [15:0] tab [NV];
   int                njobs = 0;
   logic [2:0]        job_voice [2048];
   logic              job_pluck [2048];

   always @(negedge clk) begin
      eng.eng_done = 1'b0;
      if (cnt_m > 0) begin
         cnt_m = cnt_m - 1;
         if (cnt_m == 0) begin
            eng.eng_done   = 1'b1;
            eng.eng_sample = tab[cur_voice];
         end
      end
      if (eng.eng_start === 1'b1) begin
         cur_voice = eng.eng_voice;
         cnt_m     = lat;
         if (njobs < 2048) begin
            job_voice[njobs] = eng.eng_voice;
            job_pluck[njobs] = eng.eng_pluck;
            njobs = njobs + 1;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", n_checks, n_pass);
      $fatal(1);
   end

   task automatic set_nominal_tab();
      for (int v = 0; v < NV; v++) tab[v] = 16'(1000 * v);
   endtask

   task automatic wait_mix(input int limit, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (mix_valid !== 1'b1 && n < limit);
      n_checks++;
      if (mix_valid !== 1'b1) $display("FAIL wait_mix: mix_valid=%b after %0d cycles, expected 1", mix_valid, n);
      else n_pass++;
   endtask

   task automatic wait_start_voice(input logic [2:0] v, input int limit);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(eng.eng_start === 1'b1 && eng.eng_voice === v) && n < limit);
      n_checks++;
      if (!(eng.eng_start === 1'b1 && eng.eng_voice === v))
         $display("FAIL wait_start_voice%0d: no start seen within %0d cycles", v, n);
      else n_pass++;
   endtask

   task automatic test_reset();
      int n;
      reset_reset = 1'b1;
      div_freq    = 32'd100;
      pluck_req   = '0;
      overrun_clr = 1'b0;
      lat         = 3;
      set_nominal_tab();
      repeat (3) @(negedge clk);
      n_checks++;
      if ({eng.eng_start, eng.eng_voice, eng.eng_pluck, voice_samples, mix_out, mix_valid, overrun} !== '0)
         $display("FAIL reset_outputs: start=%b voice=%0d pluck=%b mix=%0d valid=%b ovr=%b, expected all 0",
                  eng.eng_start, eng.eng_voice, eng.eng_pluck, mix_out, mix_valid, overrun);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b, expected 0", busy);
      else n_pass++;
      reset_reset = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (eng.eng_start !== 1'b1 && n < 300);
      n_checks++;
      if (n !== 100) $display("FAIL first_start_latency: got %0d cycles, expected 100", n);
      else n_pass++;
   endtask

   task automatic test_nominal();
      int n;
      int base;
      wait_mix(200, n);
      base = njobs;
      wait_mix(200, n);
      n_checks++;
      if (n !== 100) $display("FAIL nominal_period: got %0d cycles, expected 100", n);
      else n_pass++;
      n_checks++;
      if (mix_out !== 16'd7500) $display("FAIL nominal_mix: got %0d, expected 7500", $signed(mix_out));
      else n_pass++;
      n_checks++;
      if (njobs - base !== 6) $display("FAIL nominal_jobs: got %0d jobs, expected 6", njobs - base);
      else n_pass++;
      for (int j = 0; j < NV; j++) begin
         n_checks++;
         if (job_voice[base + j] !== 3'(j)) $display("FAIL voice_order%0d: got %0d, expected %0d", j, job_voice[base + j], j);
         else n_pass++;
         n_checks++;
         if (voice_samples[j*SW +: SW] !== 16'(1000 * j))
            $display("FAIL voice_sample%0d: got %0d, expected %0d", j, voice_samples[j*SW +: SW], 1000 * j);
         else n_pass++;
      end
      @(negedge clk);
      n_checks++;
      if (mix_valid !== 1'b0 || mix_out !== 16'd7500)
         $display("FAIL mix_pulse_hold: valid=%b mix=%0d, expected 0 and 7500", mix_valid, $signed(mix_out));
      else n_pass++;
   endtask

   task automatic test_saturation();
      int n;
      int sat_a [3] = '{32767, -32768, 32767};
      int sat_b [3] = '{32767, -32768, -32768};
      int sat_e [3] = '{32767, -32768, -2};
      for (int k = 0; k < 3; k++) begin
         for (int v = 0; v < NV; v++) tab[v] = (v < 3) ? 16'(sat_a[k]) : 16'(sat_b[k]);
         wait_mix(200, n);
         n_checks++;
         if (mix_out !== 16'(sat_e[k])) $display("FAIL saturation%0d: got %0d, expected %0d", k, $signed(mix_out), sat_e[k]);
         else n_pass++;
         n_checks++;
         if (voice_samples[5*SW +: SW] !== 16'(sat_b[k]))
            $display("FAIL sat_voice5_%0d: got %0d, expected %0d", k, $signed(voice_samples[5*SW +: SW]), sat_b[k]);
         else n_pass++;
      end
      set_nominal_tab();
      wait_mix(200, n);
   endtask

   task automatic test_pluck();
      int n;
      int base;
      pluck_req = 6'b001000;
      @(negedge clk);
      pluck_req = '0;
      base = njobs;
      wait_mix(200, n);
      for (int j = 0; j < NV; j++) begin
         n_checks++;
         if (job_pluck[base + j] !== (j == 3)) $display("FAIL pluck_early_v%0d: got %b, expected %b", j, job_pluck[base + j], j == 3);
         else n_pass++;
      end
      base = njobs;
      wait_start_voice(3'd4, 200);
      pluck_req = 6'b001000;
      @(negedge clk);
      pluck_req = '0;
      wait_mix(200, n);
      for (int j = 0; j < NV; j++) begin
         n_checks++;
         if (job_pluck[base + j] !== 1'b0) $display("FAIL pluck_late_same_v%0d: got %b, expected 0", j, job_pluck[base + j]);
         else n_pass++;
      end
      base = njobs;
      wait_mix(200, n);
      for (int j = 0; j < NV; j++) begin
         n_checks++;
         if (job_pluck[base + j] !== (j == 3)) $display("FAIL pluck_late_next_v%0d: got %b, expected %b", j, job_pluck[base + j], j == 3);
         else n_pass++;
      end
   endtask

   task automatic test_overrun();
      int n;
      int base;
      n_checks++;
      if (overrun !== 1'b0) $display("FAIL overrun_initial: got %b, expected 0", overrun);
      else n_pass++;
      lat      = 5;
      div_freq = 32'd20;
      wait_mix(200, n);
      wait_mix(200, n);
      base = njobs;
      wait_mix(200, n);
      n_checks++;
      if (n !== 40) $display("FAIL overrun_period: got %0d cycles, expected 40", n);
      else n_pass++;
      n_checks++;
      if (mix_out !== 16'd7500) $display("FAIL overrun_mix: got %0d, expected 7500", $signed(mix_out));
      else n_pass++;
      n_checks++;
      if (njobs - base !== 6) $display("FAIL overrun_jobs: got %0d jobs, expected 6", njobs - base);
      else n_pass++;
      for (int j = 0; j < NV; j++) begin
         n_checks++;
         if (job_voice[base + j] !== 3'(j)) $display("FAIL overrun_order%0d: got %0d, expected %0d", j, job_voice[base + j], j);
         else n_pass++;
      end
      n_checks++;
      if (overrun !== 1'b1) $display("FAIL overrun_set: got %b, expected 1", overrun);
      else n_pass++;
      overrun_clr = 1'b1;
      @(negedge clk);
      overrun_clr = 1'b0;
      n_checks++;
      if (overrun !== 1'b0) $display("FAIL overrun_clear: got %b, expected 0", overrun);
      else n_pass++;
      wait_mix(200, n);
      n_checks++;
      if (overrun !== 1'b1 || mix_out !== 16'd7500)
         $display("FAIL overrun_reset_again: ovr=%b mix=%0d, expected 1 and 7500", overrun, $signed(mix_out));
      else n_pass++;
   endtask

   task automatic test_clamp();
      int n;
      logic [31:0] divs [2] = '{32'd0, 32'd1};
      lat = 1;
      for (int k = 0; k < 2; k++) begin
         div_freq = divs[k];
         wait_mix(200, n);
         wait_mix(200, n);
         wait_mix(200, n);
         n_checks++;
         if (n !== 16) $display("FAIL clamp_div%0d: got %0d cycles, expected 16", divs[k], n);
         else n_pass++;
      end
      div_freq = 32'd40;
      wait_mix(200, n);
      n_checks++;
      if (n !== 16) $display("FAIL change_old_period: got %0d cycles, expected 16", n);
      else n_pass++;
      wait_mix(200, n);
      n_checks++;
      if (n !== 40) $display("FAIL change_new_period: got %0d cycles, expected 40", n);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int n;
      logic saw_valid;
      lat      = 3;
      div_freq = 32'd100;
      wait_mix(200, n);
      wait_start_voice(3'd2, 200);
      @(negedge clk);
      reset_reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++;
         if ({eng.eng_start, eng.eng_voice, eng.eng_pluck, voice_samples, mix_out, mix_valid, busy, overrun} !== '0)
            $display("FAIL midreset_outputs%0d: start=%b voice=%0d mix=%0d valid=%b busy=%b ovr=%b, expected all 0",
                     c, eng.eng_start, eng.eng_voice, $signed(mix_out), mix_valid, busy, overrun);
         else n_pass++;
      end
      reset_reset = 1'b0;
      saw_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (mix_valid === 1'b1) saw_valid = 1'b1;
      end while (eng.eng_start !== 1'b1 && n < 300);
      n_checks++;
      if (n !== 100 || saw_valid !== 1'b0)
         $display("FAIL midreset_restart: start after %0d cycles valid_seen=%b, expected 100 and 0", n, saw_valid);
      else n_pass++;
      wait_mix(200, n);
      n_checks++;
      if (n !== 25) $display("FAIL mix_latency: got %0d cycles from start, expected 25", n);
      else n_pass++;
      n_checks++;
      if (mix_out !== 16'd7500) $display("FAIL midreset_mix: got %0d, expected 7500", $signed(mix_out));
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_saturation();
      test_pluck();
      test_overrun();
      test_clamp();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
